// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: response-owner
// state encoding and the byte-offset width dropped from requester addresses.
package mem_port_arbiter_pkg;

  localparam logic [1:0] RSP_IDLE  = 2'd0;
  localparam logic [1:0] RSP_RD_IF = 2'd1;
  localparam logic [1:0] RSP_RD_D  = 2'd2;

  localparam int BYTE_OFF_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = RSP_IDLE,
    ST_RD_IF = RSP_RD_IF,
    ST_RD_D  = RSP_RD_D
  } rsp_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and single-port memory signals.
// slave is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if #(
  parameter int XLEN   = 32,
  parameter int AW     = 32,
  parameter int MEM_AW = 10
);

  logic              if_req;
  logic [AW-1:0]     if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [XLEN-1:0]   if_rdata;

  logic              d_req;
  logic              d_we;
  logic [AW-1:0]     d_addr;
  logic [XLEN-1:0]   d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [XLEN-1:0]   d_rdata;

  logic              stall_if;

  logic              mem_en;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN-1:0]   mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, stall_if,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, stall_if,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_streak_ctr.sv
// Counts consecutive data grants taken while fetch is waiting; saturates at
// the limit and clears whenever fetch is served or stops asking.
module arb_streak_ctr #(
  parameter int MAX_D_STREAK = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_if_req,
  input  logic       i_if_gnt,
  input  logic       i_d_gnt,
  output logic [3:0] o_streak
);

  logic [3:0] r_streak;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_streak <= '0;
    end else if (!i_if_req || i_if_gnt) begin
      r_streak <= '0;
    end else if (i_d_gnt && (r_streak != 4'(MAX_D_STREAK))) begin
      r_streak <= r_streak + 4'd1;
    end
  end

  assign o_streak = r_streak;

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: data port wins by default, fetch is forced in
// after MAX_D_STREAK data grants; read responses are steered to their owner.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int AW           = 32,
  parameter int MEM_AW       = 10,
  parameter int MAX_D_STREAK = 4
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  logic       w_d_gnt;
  logic       w_if_gnt;
  logic       w_starved;
  logic [3:0] w_streak;
  rsp_state_e r_state;

  arb_streak_ctr #(.MAX_D_STREAK(MAX_D_STREAK)) u_streak (
    .clk      (clk),
    .rst      (rst),
    .i_if_req (bus.if_req),
    .i_if_gnt (w_if_gnt),
    .i_d_gnt  (w_d_gnt),
    .o_streak (w_streak)
  );

  // Grants are gated by rst so nothing reaches the memory while in reset.
  assign w_starved = bus.if_req && (w_streak == 4'(MAX_D_STREAK));
  assign w_d_gnt   = !rst && bus.d_req && !w_starved;
  assign w_if_gnt  = !rst && bus.if_req && !w_d_gnt;

  assign bus.d_gnt    = w_d_gnt;
  assign bus.if_gnt   = w_if_gnt;
  assign bus.stall_if = !rst && bus.if_req && !w_if_gnt;

  assign bus.mem_en    = w_d_gnt || w_if_gnt;
  assign bus.mem_we    = w_d_gnt && bus.d_we;
  assign bus.mem_wdata = (w_d_gnt && bus.d_we) ? bus.d_wdata : '0;
  assign bus.mem_addr  = w_d_gnt  ? bus.d_addr[MEM_AW+BYTE_OFF_W-1:BYTE_OFF_W]  :
                         w_if_gnt ? bus.if_addr[MEM_AW+BYTE_OFF_W-1:BYTE_OFF_W] :
                                    '0;

  logic w_unused_addr_bits;
  assign w_unused_addr_bits = ^{bus.if_addr[AW-1:MEM_AW+BYTE_OFF_W], bus.if_addr[BYTE_OFF_W-1:0],
                                bus.d_addr[AW-1:MEM_AW+BYTE_OFF_W],  bus.d_addr[BYTE_OFF_W-1:0]};

  // Owner of the read issued this cycle; its data arrives next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else if (w_if_gnt) begin
      r_state <= ST_RD_IF;
    end else if (w_d_gnt && !bus.d_we) begin
      r_state <= ST_RD_D;
    end else begin
      r_state <= ST_IDLE;
    end
  end

  assign bus.if_rvalid = (r_state == ST_RD_IF);
  assign bus.d_rvalid  = (r_state == ST_RD_D);
  assign bus.if_rdata  = (r_state == ST_RD_IF) ? bus.mem_rdata : '0;
  assign bus.d_rdata   = (r_state == ST_RD_D)  ? bus.mem_rdata : '0;

endmodule
